// File: rtl/tim_apb_arb.sv
// tim_apb_arb: round-robin two-requester APB master for timer_top; define TIM_ARB_TIMEOUT_EN for an ACCESS-phase timeout
module tim_apb_arb #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [11:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_strb,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [11:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_strb,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        tim_psel,
  output logic        tim_penable,
  output logic        tim_pwrite,
  output logic [11:0] tim_paddr,
  output logic [31:0] tim_pwdata,
  output logic [3:0]  tim_pstrb,
  input  logic        tim_pready,
  input  logic        tim_pslverr,
  input  logic [31:0] tim_prdata
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_n;
  logic grant, pick, ok, go, e0, e1, to_hit, sel_write;
  logic [11:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0] sel_strb;
  always_comb begin
    ok = (state == ACCESS) & tim_pready;
    e0 = m0_req & ~(ok & ~grant);
    e1 = m1_req & ~(ok & grant);
    go = ((state == IDLE) | ok) & (e0 | e1);
    pick = (e0 & e1) ? ~grant : e1;
    sel_write = pick ? m1_write : m0_write;
    sel_addr = pick ? m1_addr : m0_addr;
    sel_wdata = pick ? m1_wdata : m0_wdata;
    sel_strb = sel_write ? (pick ? m1_strb : m0_strb) : 4'h0;
    state_n = go ? SETUP : (state == SETUP) ? ACCESS :
              ((state == ACCESS) & ~tim_pready & ~to_hit) ? ACCESS : IDLE;
  end
  assign m0_done = (ok | to_hit) & ~grant;
  assign m1_done = (ok | to_hit) & grant;
  assign m0_rdata = (ok & ~grant & ~tim_pwrite) ? tim_prdata : 32'h0;
  assign m1_rdata = (ok & grant & ~tim_pwrite) ? tim_prdata : 32'h0;
  assign m0_err = ~grant & ((ok & tim_pslverr) | to_hit);
  assign m1_err = grant & ((ok & tim_pslverr) | to_hit);
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      grant <= 1'b1;
      tim_psel <= 1'b0;
      tim_penable <= 1'b0;
      tim_pwrite <= 1'b0;
      tim_paddr <= 12'h0;
      tim_pwdata <= 32'h0;
      tim_pstrb <= 4'h0;
    end else begin
      state <= state_n;
      tim_psel <= state_n != IDLE;
      tim_penable <= state_n == ACCESS;
      if (go) begin
        grant <= pick;
        tim_pwrite <= sel_write;
        tim_paddr <= sel_addr;
        tim_pwdata <= sel_wdata;
        tim_pstrb <= sel_strb;
      end
    end
  end
`ifdef TIM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign to_hit = (state == ACCESS) & ~tim_pready & (cnt == CW'(TIMEOUT_CYC - 1));
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt <= '0;
    else cnt <= ((state == ACCESS) & ~tim_pready & ~to_hit) ? cnt + 1'b1 : '0;
  end
`else
  assign to_hit = 1'b0 & (TIMEOUT_CYC > 0);
`endif
endmodule

// File: tb/tb_tim_apb_arb.sv
// tb_tim_apb_arb: vector table, directed corner cases and randomized run against a rule-level model
module tb_tim_apb_arb;
  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic [1:0] req = '0, write = '0, done, err;
  logic [1:0][11:0] addr = '0;
  logic [1:0][31:0] wdata = '0, rdata;
  logic [1:0][3:0] strb = '0;
  logic tim_psel, tim_penable, tim_pwrite, tim_pready = 1'b0, tim_pslverr = 1'b0;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata, tim_prdata = '0;
  logic [3:0] tim_pstrb;
  int total = 0, bad = 0;

  tim_apb_arb #(.TIMEOUT_CYC(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m0_req(req[0]), .m0_write(write[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_strb(strb[0]),
    .m0_done(done[0]), .m0_rdata(rdata[0]), .m0_err(err[0]),
    .m1_req(req[1]), .m1_write(write[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_strb(strb[1]),
    .m1_done(done[1]), .m1_rdata(rdata[1]), .m1_err(err[1]),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_pready(tim_pready), .tim_pslverr(tim_pslverr), .tim_prdata(tim_prdata)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset;
    req = '0;
    tim_pready = 1'b0;
    tim_pslverr = 1'b0;
    #2 sys_rst_n = 1'b0;
    #4 sys_rst_n = 1'b1;
  endtask

  typedef struct {
    int id;
    logic wr;
    logic [11:0] a;
    logic [31:0] wd;
    logic [3:0] st;
    int waits;
    logic [31:0] prd;
    logic slv;
    logic [31:0] x_rdata;
    logic x_err;
    logic [3:0] x_strb;
  } vec_t;
  vec_t tbl[6];

  task automatic run_vec(input vec_t v);
    int ps = 0, pe = 0, acc = 0, nd = 0, nother = 0;
    bit fin = 0;
    write[v.id] = v.wr; addr[v.id] = v.a; wdata[v.id] = v.wd; strb[v.id] = v.st; req[v.id] = 1'b1;
    for (int c = 0; c < 20 && !fin; c++) begin
      tick;
      if (tim_psel && tim_penable) begin
        acc++;
        tim_pready = acc > v.waits;
        tim_prdata = v.prd;
        tim_pslverr = v.slv;
      end else begin
        tim_pready = 1'b0;
        tim_prdata = 32'hFFFF_FFFF;
      end
      #1;
      ps += int'(tim_psel);
      pe += int'(tim_penable);
      nother += int'(done[1-v.id]);
      if (done[v.id]) begin
        nd++;
        fin = 1;
        chk("vec_rdata", rdata[v.id], v.x_rdata);
        chk("vec_err", err[v.id], v.x_err);
        chk("vec_pstrb", tim_pstrb, v.x_strb);
        chk("vec_paddr", tim_paddr, v.a);
        chk("vec_pwrite", tim_pwrite, v.wr);
        if (v.wr) chk("vec_pwdata", tim_pwdata, v.wd);
        req[v.id] = 1'b0;
      end
    end
    tick;
    tim_pready = 1'b0;
    tim_pslverr = 1'b0;
    #1;
    chk("vec_idle_after", tim_psel, 0);
    chk("vec_psel_cycles", ps, v.waits + 2);
    chk("vec_penable_cycles", pe, v.waits + 1);
    chk("vec_done_pulses", nd, 1);
    chk("vec_other_done", nother, 0);
  endtask

  int mph, mown, mlast, wcnt, wtarget, k, acc, nd;
  logic [11:0] e_addr;
  logic e_wr;
  logic [31:0] e_wd;
  logic [3:0] e_st;
  bit cmp, fin;

  initial begin
    tbl[0] = '{0, 1'b1, 12'h000, 32'h0000_0201, 4'hF, 1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 4'hF};
    tbl[1] = '{1, 1'b1, 12'hFFC, 32'h1234_5678, 4'h3, 0, 32'h7777_7777, 1'b1, 32'h0, 1'b1, 4'h3};
    tbl[2] = '{0, 1'b0, 12'h004, 32'h0BAD_0BAD, 4'hF, 0, 32'hA5A5_0004, 1'b0, 32'hA5A5_0004, 1'b0, 4'h0};
    tbl[3] = '{1, 1'b0, 12'h008, 32'h0, 4'hF, 2, 32'h5A5A_0008, 1'b0, 32'h5A5A_0008, 1'b0, 4'h0};
    tbl[4] = '{1, 1'b0, 12'h010, 32'h0, 4'h0, 0, 32'hCAFE_0000, 1'b1, 32'hCAFE_0000, 1'b1, 4'h0};
    tbl[5] = '{0, 1'b1, 12'h00C, 32'hFFFF_FFFF, 4'h5, 3, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 4'h5};

    tim_pready = 1'b1; tim_pslverr = 1'b1; tim_prdata = 32'hFFFF_FFFF; req = 2'b11;
    #3;
    chk("rst_psel", tim_psel, 0);
    chk("rst_penable", tim_penable, 0);
    chk("rst_pwrite", tim_pwrite, 0);
    chk("rst_paddr", tim_paddr, 0);
    chk("rst_pwdata", tim_pwdata, 0);
    chk("rst_pstrb", tim_pstrb, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata0", rdata[0], 0);
    chk("rst_rdata1", rdata[1], 0);
    req = '0; tim_pready = 1'b0; tim_pslverr = 1'b0;
    #19 sys_rst_n = 1'b1;
    tick;
    foreach (tbl[i]) run_vec(tbl[i]);

    do_reset;
    write = '0; addr[0] = 12'h004; addr[1] = 12'h008; req = 2'b11;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      tick;
      tim_pready = tim_psel & tim_penable;
      tim_prdata = 32'h1000 + c;
      #1;
      if (done[0] | done[1]) begin
        chk("rr_owner", done[1], k % 2);
        chk("rr_single_done", done[0] & done[1], 0);
        chk("rr_rdata", rdata[done[1]], 32'h1000 + c);
        chk("rr_paddr", tim_paddr, (k % 2) ? 12'h008 : 12'h004);
        k++;
      end
    end
    chk("rr_count", k, 4);

    tick;
    do_reset;
    tick;
    write[0] = 1'b0; addr[0] = 12'h004; req[0] = 1'b1;
    tick;
    tick;
    #1;
    chk("abort_in_access", {tim_psel, tim_penable}, 2'b11);
    sys_rst_n = 1'b0;
    #1;
    chk("abort_psel", tim_psel, 0);
    chk("abort_penable", tim_penable, 0);
    tim_pready = 1'b1;
    #1;
    chk("abort_no_done", done[0], 0);
    sys_rst_n = 1'b1;
    tick;
    #1;
    chk("abort_restart_setup", {tim_psel, tim_penable}, 2'b10);
    chk("abort_restart_done", done[0], 0);
    tick;
    tim_prdata = 32'h0000_00AB;
    #1;
    chk("abort_restart_complete", done[0], 1);
    chk("abort_restart_rdata", rdata[0], 32'hAB);
    req[0] = 1'b0;

    tick;
    do_reset;
    tick;
    write[0] = 1'b0; addr[0] = 12'h020; req[0] = 1'b1;
    tim_prdata = 32'h5555_AAAA;
    acc = 0; nd = 0; fin = 0;
`ifdef TIM_ARB_TIMEOUT_EN
    for (int c = 0; c < 20 && !fin; c++) begin
      tick;
      #1;
      acc += int'(tim_penable);
      if (done[0]) begin
        fin = 1;
        chk("to_cycle", acc, 4);
        chk("to_err", err[0], 1);
        chk("to_rdata", rdata[0], 0);
        req[0] = 1'b0;
      end
    end
    chk("to_seen", fin, 1);
    tick;
    #1;
    chk("to_idle", tim_psel, 0);
`else
    for (int c = 0; c < 101; c++) begin
      tick;
      #1;
      acc += int'(tim_psel & tim_penable);
      nd += int'(done[0] | done[1]);
    end
    chk("hold_access_cycles", acc, 100);
    chk("hold_no_done", nd, 0);
    tim_pready = 1'b1;
    #1;
    chk("hold_release_done", done[0], 1);
    req[0] = 1'b0;
`endif

    tick;
    do_reset;
    mph = 0; mown = 0; mlast = 1; wcnt = 0; wtarget = 0;
    e_addr = '0; e_wr = 1'b0; e_wd = '0; e_st = '0;
    for (int c = 0; c < 500; c++) begin
      tick;
      tim_pready = (mph == 2) ? (wcnt == wtarget) : 1'($urandom_range(0, 1));
      tim_prdata = $urandom;
      tim_pslverr = 1'($urandom_range(0, 1));
      #1;
      cmp = (mph == 2) && tim_pready;
      chk("rnd_psel", tim_psel, mph != 0);
      chk("rnd_penable", tim_penable, mph == 2);
      chk("rnd_paddr", tim_paddr, e_addr);
      chk("rnd_pwrite", tim_pwrite, e_wr);
      chk("rnd_pwdata", tim_pwdata, e_wd);
      if (mph != 0) chk("rnd_pstrb", tim_pstrb, e_wr ? e_st : 4'h0);
      for (int n = 0; n < 2; n++) begin
        bit xd;
        xd = cmp && (mown == n);
        chk("rnd_done", done[n], xd);
        chk("rnd_rdata", rdata[n], (xd && !e_wr) ? tim_prdata : 32'h0);
        chk("rnd_err", err[n], xd && tim_pslverr);
        if (xd ? ($urandom_range(0, 1) == 1) : (!req[n] && $urandom_range(0, 2) == 0)) begin
          req[n] = 1'b1;
          write[n] = 1'($urandom_range(0, 1));
          addr[n] = 12'($urandom);
          wdata[n] = $urandom;
          strb[n] = 4'($urandom);
        end else if (xd) begin
          req[n] = 1'b0;
        end
      end
      if ((mph == 0 || cmp) && ((req[0] && !(cmp && mown == 0)) || (req[1] && !(cmp && mown == 1)))) begin
        if ((req[0] && !(cmp && mown == 0)) && (req[1] && !(cmp && mown == 1))) mown = 1 - mlast;
        else mown = (req[1] && !(cmp && mown == 1)) ? 1 : 0;
        mlast = mown;
        mph = 1;
        e_addr = addr[mown]; e_wr = write[mown]; e_wd = wdata[mown]; e_st = strb[mown];
      end else if (mph == 1) begin
        mph = 2;
        wcnt = 0;
        wtarget = $urandom_range(0, 3);
      end else if (mph == 2) begin
        if (cmp) mph = 0;
        else wcnt++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
